// File: rtl/result_drain.sv
// Drains the accelerator result memory from address 0 upward after a done pulse,
// streaming words over valid/ready through a 3-entry read-ahead buffer.
module result_drain #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              drained
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [ADDR_W:0] ONE = 1;

  state_t                   st, st_nx;
  logic [ADDR_W:0]          n_q, issued, accepted;
  logic                     inflight;
  logic [1:0]               occ, wi;
  logic [2:0][DATA_W-1:0]   fifo;
  logic [2:0]               pend;
  logic                     pop, push, last_hs;

  // Read-ahead budget counts words already buffered plus the read still in flight,
  // both registered, so the issue decision never depends on out_ready.
  assign pend      = {1'b0, occ} + {2'b00, inflight};
  assign mem_ren   = (st == RUN) && (issued < n_q) && (pend < 3'd3);
  assign mem_addr  = issued[ADDR_W-1:0];
  assign push      = inflight;
  assign out_valid = (occ != 2'd0);
  assign out_data  = fifo[0];
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (accepted == n_q - ONE);
  assign last_hs   = (st == RUN) && pop && (accepted == n_q - ONE);
  assign wi        = occ - {1'b0, pop};
  assign busy      = (st != IDLE);
  assign drained   = (st == FIN);

  always_comb begin
    st_nx = st;
    case (st)
      IDLE: if (start) st_nx = (num_words == '0) ? FIN : RUN;
      RUN:  if (last_hs) st_nx = FIN;
      FIN:  st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      n_q      <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
    end else begin
      st       <= st_nx;
      inflight <= mem_ren;
      if (st == IDLE && start) begin
        n_q      <= num_words;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (mem_ren) issued <= issued + ONE;
        if (pop && st == RUN) accepted <= accepted + ONE;
      end
    end
  end

  // Shift-register FIFO: entry 0 is always the head, so out_data needs no mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= 2'd0;
      fifo <= '0;
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      for (int i = 0; i < 3; i++) begin
        if (pop && i < 2) fifo[i] <= fifo[i+1];
        if (push && wi == 2'(i)) fifo[i] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: expected words queued at start, checked on handshake.
module tb_result_drain;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready = 1'b1;
  logic              busy;
  logic              drained;

  result_drain #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .drained(drained)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [64];
  logic [DATA_W:0]   q [$];
  logic [63:0]       addr_seen;
  logic              stalled_prev = 1'b0;
  logic [DATA_W-1:0] held_d;
  int ntests = 0, nfail = 0;
  int exp_addr = 0, rd_cnt = 0, pop_cnt = 0, drn_cnt = 0;

  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input int n);
    for (int i = 0; i < n; i++) q.push_back({(i == n - 1), mem[i]});
    exp_addr = 0; rd_cnt = 0; pop_cnt = 0; addr_seen = '0;
    start = 1'b1;
    num_words = (ADDR_W+1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drained(input int budget, input bit rnd);
    int d0 = drn_cnt;
    int k = 0;
    while (drn_cnt == d0 && k < budget) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    out_ready = 1'b1;
    chk("drain_timeout", 32'(drn_cnt != d0), 32'd1);
    chk("sb_leftover", 32'(q.size()), 32'd0);
  endtask

  // Monitor samples on the falling edge, half a cycle from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (mem_ren) begin
        chk("addr", 32'(mem_addr), 32'(exp_addr));
        chk("readahead", 32'((rd_cnt - pop_cnt) < 3), 32'd1);
        addr_seen[mem_addr] = 1'b1;
        exp_addr++;
        rd_cnt++;
      end
      if (stalled_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'(out_data), 32'(held_d));
      end
      stalled_prev = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_extra", 32'd1, 32'd0);
        else begin
          logic [DATA_W:0] e;
          e = q.pop_front();
          chk("data", 32'(out_data), 32'(e[DATA_W-1:0]));
          chk("last", 32'(out_last), 32'(e[DATA_W]));
        end
        pop_cnt++;
      end
      if (drained) drn_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ren",   32'(mem_ren), 0);
    chk("rst_addr",  32'(mem_addr), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_busy",  32'({busy, drained, out_last}), 0);
    tick();
    rst = 1'b0;
    tick();

    // N=4, ready held high: exact cycle timeline
    drive_start(4);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t1_ren_c%0d", k),   32'(mem_ren),   32'(k >= 1 && k <= 4));
      if (mem_ren) chk($sformatf("t1_addr_c%0d", k), 32'(mem_addr), 32'(k - 1));
      chk($sformatf("t1_valid_c%0d", k), 32'(out_valid), 32'(k >= 3 && k <= 6));
      chk($sformatf("t1_last_c%0d", k),  32'(out_last),  32'(k == 6));
      chk($sformatf("t1_drn_c%0d", k),   32'(drained),   32'(k == 7));
      chk($sformatf("t1_busy_c%0d", k),  32'(busy),      32'(k <= 7));
      tick();
    end
    chk("t1_words", 32'(pop_cnt), 4);
    chk("t1_sb", 32'(q.size()), 0);

    // N=10 with consumer stalled in cycles 2..9
    drive_start(10);
    tick();
    out_ready = 1'b0;
    repeat (7) tick();
    chk("t2_reads_before_pop", 32'(rd_cnt), 3);
    chk("t2_no_pop", 32'(pop_cnt), 0);
    tick();
    out_ready = 1'b1;
    wait_drained(100, 1'b0);
    chk("t2_words", 32'(pop_cnt), 10);

    // N=0: immediate completion, no reads
    drive_start(0);
    chk("t3_drn", 32'(drained), 1);
    chk("t3_busy", 32'(busy), 1);
    chk("t3_ren", 32'(mem_ren), 0);
    tick();
    chk("t3_drn_off", 32'(drained), 0);
    chk("t3_busy_off", 32'(busy), 0);
    chk("t3_reads", 32'(rd_cnt), 0);

    // start re-asserted during RUN is ignored
    begin
      int d0;
      d0 = drn_cnt;
      drive_start(6);
      tick();
      start = 1'b1; num_words = 7'd2;
      tick();
      start = 1'b0;
      wait_drained(100, 1'b0);
      repeat (4) tick();
      chk("t4_words", 32'(pop_cnt), 6);
      chk("t4_drn_pulses", 32'(drn_cnt - d0), 1);
      drive_start(5);
      wait_drained(100, 1'b0);
      chk("t4_words2", 32'(pop_cnt), 5);
    end

    // async reset mid-drain after word 2 accepted
    begin
      int k = 0;
      drive_start(8);
      while (pop_cnt < 2 && k < 50) begin tick(); k++; end
      chk("t5_reach2", 32'(pop_cnt), 2);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_valid", 32'(out_valid), 0);
      chk("t5_rst_ren", 32'(mem_ren), 0);
      chk("t5_rst_misc", 32'({busy, drained, out_last}), 0);
      chk("t5_rst_data", 32'(out_data), 0);
      chk("t5_rst_addr", 32'(mem_addr), 0);
      q.delete();
      tick(); tick();
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
        chk("t5_no_stale", 32'(out_valid), 0);
        tick();
      end
      drive_start(3);
      wait_drained(100, 1'b0);
      chk("t5_words", 32'(pop_cnt), 3);
    end

    // N=64, random backpressure
    drive_start(64);
    wait_drained(2000, 1'b1);
    chk("t6_words", 32'(pop_cnt), 64);
    chk("t6_addr_cov", 32'(&addr_seen), 1);
    chk("t6_reads", 32'(rd_cnt), 64);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
